uart_tx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_cfg.sv | 143 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Total line bits in one frame: start + payload + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_CLK-1 while enabled and ticks o_bit_end on the last count.
// Combinational tick, no backpressure; a sync clear restarts the period and disabling parks it at 0.
module uart_baud_gen #(
  parameter int BAUD_CLK = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int CW = (BAUD_CLK > 1) ? $clog2(BAUD_CLK) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap    = (r_cnt == CW'(BAUD_CLK - 1));
  assign o_bit_end = i_en && w_wrap;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with 5-9 data bits, none/odd/even parity, 1-2 stop bits; line goes low 1 cycle after accept.
// Ready only in IDLE or the final stop cycle, so a held valid chains frames with no idle gap.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_valid_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 tx_done,
  output logic                 uart_tx
);

  localparam int BAUD_CLK   = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int BIT_CW     = $clog2(FRAME_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (BAUD_CLK < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_CW-1:0]    r_bit_cnt;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  logic w_accept;
  logic w_bit_end;
  logic w_baud_en;
  logic w_last_stop;
  logic w_par;

  assign w_baud_en   = (r_state != ST_IDLE);
  assign w_last_stop = (r_bit_cnt == BIT_CW'(STOP_BITS - 1));
  assign tx_ready_o  = (r_state == ST_IDLE) || (r_state == ST_STOP && w_last_stop && w_bit_end);
  assign w_accept    = tx_valid_i && tx_ready_o;
  assign w_par       = (PARITY == PARITY_ODD) ? ~(^tx_data_i) : (^tx_data_i);
  assign tx_busy_o   = (r_state != ST_IDLE);
  assign tx_done     = r_done;
  assign uart_tx     = r_tx;

  uart_baud_gen #(
    .BAUD_CLK (BAUD_CLK)
  ) u_baud_gen (
    .clk       (clk),
    .rstn      (rstn),
    .i_en      (w_baud_en),
    .i_clr     (w_accept),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_tx      <= 1'b1;
          r_bit_cnt <= '0;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == BIT_CW'(DATA_BITS - 1)) begin
              r_bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state   <= ST_STOP;
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_done    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Acceptance only happens in IDLE or the final stop cycle and overrides the state update.
      if (w_accept) begin
        r_state   <= ST_START;
        r_tx      <= 1'b0;
        r_shift   <= tx_data_i;
        r_par     <= w_par;
        r_bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three configurations at BAUD_CLK=10, line sampled mid-bit.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rstn;
  logic       vld  [3];
  logic [8:0] td;
  logic       rdy  [3];
  logic       busy [3];
  logic       done [3];
  logic       txl  [3];

  int sel;
  int errors;
  int checks;

  logic tx_m, rdy_m, busy_m, done_m;
  assign tx_m   = txl[sel];
  assign rdy_m  = rdy[sel];
  assign busy_m = busy[sel];
  assign done_m = done[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rstn(rstn), .tx_valid_i(vld[0]), .tx_data_i(td[7:0]),
    .tx_ready_o(rdy[0]), .tx_busy_o(busy[0]), .tx_done(done[0]), .uart_tx(txl[0]));

  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rstn(rstn), .tx_valid_i(vld[1]), .tx_data_i(td[7:0]),
    .tx_ready_o(rdy[1]), .tx_busy_o(busy[1]), .tx_done(done[1]), .uart_tx(txl[1]));

  uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rstn(rstn), .tx_valid_i(vld[2]), .tx_data_i(td[6:0]),
    .tx_ready_o(rdy[2]), .tx_busy_o(busy[2]), .tx_done(done[2]), .uart_tx(txl[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the selected instance idle; returns on the first start-bit cycle.
  task automatic start_frame(input string tag, input logic [8:0] d);
    vld[sel] = 1'b1;
    td       = d;
    chk({tag, " ready_idle"}, rdy_m, 1);
    chk({tag, " line_idle"}, tx_m, 1);
    @(negedge clk);
  endtask

  // c counts cycles from the first start-bit cycle; expf bit k is the k-th line bit.
  task automatic watch(input string tag, input int n, input logic [15:0] expf,
                       input logic nv, input logic [8:0] nd);
    int bad_ready = 0;
    int bad_done  = 0;
    int bad_busy  = 0;
    for (int c = 0; c <= n * 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        vld[sel] = nv;
        td       = nd;
        chk({tag, " start_latency"}, tx_m, 0);
      end
      if (c < n * 10) begin
        if (c % 10 == 5) chk($sformatf("%s bit%0d", tag, c / 10), tx_m, expf[c / 10]);
        if (rdy_m !== 1'(c == n * 10 - 1)) bad_ready++;
        if (c > 0 && done_m !== 1'b0) bad_done++;
        if (busy_m !== 1'b1) bad_busy++;
      end else begin
        chk({tag, " done_at_end"}, done_m, 1);
        chk({tag, " line_after"}, tx_m, nv ? 0 : 1);
        chk({tag, " busy_after"}, busy_m, nv);
      end
    end
    chk({tag, " ready_cycles_bad"}, bad_ready, 0);
    chk({tag, " early_done_bad"}, bad_done, 0);
    chk({tag, " busy_bad"}, busy_bad_dummy(bad_busy), 0);
  endtask

  function automatic int busy_bad_dummy(input int v);
    return v;
  endfunction

  initial begin
    int bad;
    errors = 0;
    checks = 0;
    sel    = 0;
    rstn   = 1'b0;
    td     = '0;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx%0d", i), txl[i], 1);
      chk($sformatf("rst_done%0d", i), done[i], 0);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("ready_after_rst%0d", i), rdy[i], 1);

    // 8N1 0xA5: 0, 1,0,1,0,0,1,0,1, 1
    sel = 0;
    @(negedge clk);
    start_frame("8n1_a5", 9'h0A5);
    watch("8n1_a5", 10, 16'h034A, 1'b0, 9'h000);

    // 8E1 0x07: three ones, even parity bit 1
    sel = 1;
    repeat (3) @(negedge clk);
    start_frame("8e1_07", 9'h007);
    watch("8e1_07", 11, 16'h060E, 1'b0, 9'h000);

    // 7O2 0x55: four ones, odd parity bit 1, two stop bits -> 11 line bits
    sel = 2;
    repeat (3) @(negedge clk);
    start_frame("7o2_55", 9'h055);
    watch("7o2_55", 11, 16'h07AA, 1'b0, 9'h000);

    // Back-to-back 0x12 then 0x34 with valid held
    sel = 0;
    repeat (3) @(negedge clk);
    start_frame("b2b_12", 9'h012);
    watch("b2b_12", 10, 16'h0224, 1'b1, 9'h034);
    watch("b2b_34", 10, 16'h0268, 1'b0, 9'h000);

    // Input data changes to 0xFF right after acceptance
    repeat (3) @(negedge clk);
    start_frame("hold_a5", 9'h0A5);
    watch("hold_a5", 10, 16'h034A, 1'b0, 9'h0FF);

    // Reset in the middle of data bit 3 (line bit 4, cycles 40..49)
    repeat (3) @(negedge clk);
    start_frame("rst_mid", 9'h0A5);
    vld[0] = 1'b0;
    repeat (45) @(negedge clk);
    chk("rst_mid pre_line", tx_m, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid line", tx_m, 1);
    chk("rst_mid busy", busy_m, 0);
    chk("rst_mid done", done_m, 0);
    rstn = 1'b1;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_m !== 1'b0 || tx_m !== 1'b1 || rdy_m !== 1'b1) bad++;
    end
    chk("rst_mid quiet_after", bad, 0);
    start_frame("post_rst_3c", 9'h03C);
    watch("post_rst_3c", 10, 16'h0278, 1'b0, 9'h000);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
